// File: rtl/fp_sqrt_unpack.sv
// fp_sqrt_unpack: operand front end for the iterative single-precision sqrt core.
// Captures the operand, classifies special values, normalises denormals one bit
// per clock, evens out the exponent and hands over a significand plus the
// pre-halved biased result exponent together with a one-cycle done pulse.
// Build option: define FP_SQRT_UNPACK_FTZ_EN to flush denormal operands to
// signed zero; the NORM state is then not built.
`timescale 1ns/1ps

module fp_sqrt_unpack #(
  parameter int unsigned           EXP_W  = 8,
  parameter int unsigned           FRAC_W = 23,
  parameter logic [EXP_W+FRAC_W:0] QNAN   = 32'h7FC00000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   A,
  output logic                    busy,
  output logic                    done,
  output logic [FRAC_W+1:0]       mant_out,
  output logic [EXP_W-1:0]        exp_out,
  output logic [1:0]              sclass,
  output logic [EXP_W+FRAC_W:0]   special_result
);

  localparam int unsigned OP_W    = 1 + EXP_W + FRAC_W;
  localparam int          BiasInt = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EXP_W+1:0] Bias  = (EXP_W+2)'(BiasInt);
  localparam logic signed [EXP_W+1:0] EOne  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EZero = '0;
`ifndef FP_SQRT_UNPACK_FTZ_EN
  // Unbiased exponent of every denormal before normalisation.
  localparam logic signed [EXP_W+1:0] EDen  = (EXP_W+2)'(1 - BiasInt);
`endif

  localparam logic [OP_W-1:0] QuietBit = {{(EXP_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [OP_W-1:0] PosInf   = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  localparam logic [1:0] ClsNormal = 2'd0;
  localparam logic [1:0] ClsZero   = 2'd1;
  localparam logic [1:0] ClsInf    = 2'd2;
  localparam logic [1:0] ClsNan    = 2'd3;

`ifdef FP_SQRT_UNPACK_FTZ_EN
  typedef enum logic [2:0] {StIdle, StLoad, StAdjust, StDone} state_t;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StNorm, StAdjust, StDone} state_t;
`endif

  state_t                  state;
  logic [OP_W-1:0]         a_q;
  logic [FRAC_W+1:0]       mant;
  logic signed [EXP_W+1:0] e_unb;

  // Operand fields of the captured value.
  logic              a_sign;
  logic [EXP_W-1:0]  a_exp;
  logic [FRAC_W-1:0] a_frac;
  logic              exp_zero, exp_ones, frac_zero;

  assign a_sign    = a_q[OP_W-1];
  assign a_exp     = a_q[OP_W-2:FRAC_W];
  assign a_frac    = a_q[FRAC_W-1:0];
  assign exp_zero  = ~|a_exp;
  assign exp_ones  = &a_exp;
  assign frac_zero = ~|a_frac;

  assign busy = (state != StIdle);
  assign done = (state == StDone);

  // Classification of the captured operand, consumed in LOAD.
  logic [1:0]      cls;
  logic [OP_W-1:0] cls_result;
  logic            is_special;
`ifndef FP_SQRT_UNPACK_FTZ_EN
  logic            is_denorm;
`endif

  // Decide the special-case class and its final result.
  always_comb begin
    cls        = ClsNormal;
    cls_result = '0;
    is_special = 1'b1;
`ifndef FP_SQRT_UNPACK_FTZ_EN
    is_denorm  = 1'b0;
`endif
    if (exp_zero && frac_zero) begin
      cls        = ClsZero;
      cls_result = a_q;
    end else if (exp_zero) begin
`ifdef FP_SQRT_UNPACK_FTZ_EN
      cls        = ClsZero;
      cls_result = {a_sign, {(OP_W-1){1'b0}}};
`else
      if (a_sign) begin
        cls        = ClsNan;
        cls_result = QNAN;
      end else begin
        is_special = 1'b0;
        is_denorm  = 1'b1;
      end
`endif
    end else if (exp_ones && !frac_zero) begin
      cls        = ClsNan;
      cls_result = a_q | QuietBit;
    end else if (a_sign) begin
      cls        = ClsNan;
      cls_result = QNAN;
    end else if (exp_ones) begin
      cls        = ClsInf;
      cls_result = PosInf;
    end else begin
      is_special = 1'b0;
    end
  end

  // Odd exponent: borrow one from the exponent into the significand, then halve exactly.
  logic [FRAC_W+1:0]       mant_adj;
  logic signed [EXP_W+1:0] e_adj;
  logic signed [EXP_W+1:0] e_res;
  logic                    unused_e_res;

  // Even-exponent adjustment and halved biased exponent.
  always_comb begin
    mant_adj = e_unb[0] ? {mant[FRAC_W:0], 1'b0} : mant;
    e_adj    = e_unb - (e_unb[0] ? EOne : EZero);
    e_res    = (e_adj >>> 1) + Bias;
  end

  assign unused_e_res = ^e_res[EXP_W+1:EXP_W];

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      a_q            <= '0;
      mant           <= '0;
      e_unb          <= '0;
      mant_out       <= '0;
      exp_out        <= '0;
      sclass         <= '0;
      special_result <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            a_q   <= A;
            state <= StLoad;
          end
        end
        StLoad: begin
          sclass         <= cls;
          special_result <= cls_result;
          if (is_special) begin
            mant_out <= '0;
            exp_out  <= '0;
            state    <= StDone;
`ifndef FP_SQRT_UNPACK_FTZ_EN
          end else if (is_denorm) begin
            mant  <= {2'b00, a_frac};
            e_unb <= EDen;
            state <= StNorm;
`endif
          end else begin
            mant  <= {2'b01, a_frac};
            e_unb <= $signed({2'b00, a_exp}) - Bias;
            state <= StAdjust;
          end
        end
`ifndef FP_SQRT_UNPACK_FTZ_EN
        StNorm: begin
          mant  <= {mant[FRAC_W:0], 1'b0};
          e_unb <= e_unb - EOne;
          // Leave once the shifted value carries the hidden one.
          if (mant[FRAC_W-1]) begin
            state <= StAdjust;
          end
        end
`endif
        StAdjust: begin
          mant_out <= mant_adj;
          exp_out  <= e_res[EXP_W-1:0];
          state    <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_unpack.sv
// Self-checking bench for fp_sqrt_unpack: directed vector table, randomized
// operands against an arithmetic reference model, and hand-written sequences
// for start-while-busy, start-in-DONE and reset during normalisation.
`timescale 1ns/1ps

module tb_fp_sqrt_unpack;

`ifdef FP_SQRT_UNPACK_FTZ_EN
  localparam bit Ftz = 1'b1;
`else
  localparam bit Ftz = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic        busy;
  logic        done;
  logic [24:0] mant_out;
  logic [7:0]  exp_out;
  logic [1:0]  sclass;
  logic [31:0] special_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_sqrt_unpack dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .A              (a_in),
    .busy           (busy),
    .done           (done),
    .mant_out       (mant_out),
    .exp_out        (exp_out),
    .sclass         (sclass),
    .special_result (special_result)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  cls;
    logic [31:0] res;
    logic [24:0] mant;
    logic [7:0]  ex;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: value = sig * 2^e, normalise by doubling, force even e, halve.
  task automatic model(input logic [31:0] a, output logic [1:0] cls, output logic [31:0] res,
                       output logic [24:0] mant, output logic [7:0] ex, output int lat);
    logic        sgn;
    int          e;
    longint      m;
    int          ue;
    int          k;
    sgn  = a[31];
    e    = int'(a[30:23]);
    m    = longint'(a[22:0]);
    cls  = 2'd0;
    res  = 32'h0;
    mant = '0;
    ex   = '0;
    lat  = 2;
    if (e == 255 && m != 0) begin
      cls = 2'd3;
      res = a | 32'h0040_0000;
    end else if (e == 0 && m == 0) begin
      cls = 2'd1;
      res = a;
    end else if (Ftz && e == 0) begin
      cls = 2'd1;
      res = sgn ? 32'h8000_0000 : 32'h0;
    end else if (sgn) begin
      cls = 2'd3;
      res = 32'h7FC0_0000;
    end else if (e == 255) begin
      cls = 2'd2;
      res = 32'h7F80_0000;
    end else begin
      if (e == 0) ue = -126;
      else begin
        ue = e - 127;
        m  = m + (64'd1 << 23);
      end
      k = 0;
      while (m < (64'd1 << 23)) begin
        m  = m * 2;
        ue = ue - 1;
        k++;
      end
      if (ue % 2 != 0) begin
        m  = m * 2;
        ue = ue - 1;
      end
      mant = m[24:0];
      ex   = 8'(ue / 2 + 127);
      lat  = (e == 0) ? 3 + k : 3;
    end
  endtask

  // One operation: optional stray start at edge gedge, optional start held in DONE.
  task automatic run_op(input logic [31:0] a, input logic [1:0] e_cls, input logic [31:0] e_res,
                        input logic [24:0] e_mant, input logic [7:0] e_ex, input int e_lat,
                        input logic [31:0] ga, input int gedge, input bit hold,
                        input string tag);
    int edges;
    bit got;
    bit busy_ok;
    @(negedge clk);
    a_in    = a;
    start   = 1'b1;
    edges   = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) start = 1'b0;
      if (gedge > 0 && edges == gedge) begin
        start = 1'b1;
        a_in  = ga;
      end
      if (gedge > 0 && edges == gedge + 1) start = 1'b0;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 32'(edges), 32'(e_lat));
    check({tag, " busy while active"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " sclass"}, {30'd0, sclass}, {30'd0, e_cls});
    check({tag, " special_result"}, special_result, e_res);
    if (e_cls == 2'd0) begin
      check({tag, " mant_out"}, {7'd0, mant_out}, {7'd0, e_mant});
      check({tag, " exp_out"}, {24'd0, exp_out}, {24'd0, e_ex});
    end
    if (hold) begin
      start = 1'b1;
      a_in  = 32'h4000_0000;
    end
    @(posedge clk);
    #1;
    check({tag, " done/busy after done"}, {30'd0, done, busy}, 32'd0);
    check({tag, " outputs held"}, special_result, e_res);
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  m_cls;
    logic [31:0] m_res;
    logic [24:0] m_mant;
    logic [7:0]  m_ex;
    int          m_lat;
    logic [31:0] ra;

    vecs[0]  = '{32'h3F80_0000, 2'd0, 32'h0, 25'h080_0000, 8'h7F, 3};
    vecs[1]  = '{32'h4080_0000, 2'd0, 32'h0, 25'h080_0000, 8'h80, 3};
    vecs[2]  = '{32'h4000_0000, 2'd0, 32'h0, 25'h100_0000, 8'h7F, 3};
    vecs[3]  = '{32'h8000_0000, 2'd1, 32'h8000_0000, 25'h0, 8'h0, 2};
    vecs[4]  = '{32'h7F80_0000, 2'd2, 32'h7F80_0000, 25'h0, 8'h0, 2};
    vecs[5]  = '{32'hC080_0000, 2'd3, 32'h7FC0_0000, 25'h0, 8'h0, 2};
    vecs[6]  = '{32'h7F80_0001, 2'd3, 32'h7FC0_0001, 25'h0, 8'h0, 2};
    vecs[7]  = '{32'hFF80_0000, 2'd3, 32'h7FC0_0000, 25'h0, 8'h0, 2};
    vecs[8]  = '{32'hFFC0_0000, 2'd3, 32'hFFC0_0000, 25'h0, 8'h0, 2};
    vecs[9]  = '{32'h7F7F_FFFF, 2'd0, 32'h0, 25'h1FF_FFFE, 8'hBE, 3};
    vecs[10] = '{32'h0080_0000, 2'd0, 32'h0, 25'h080_0000, 8'h40, 3};
    vecs[11] = '{32'h0000_0000, 2'd1, 32'h0, 25'h0, 8'h0, 2};
`ifdef FP_SQRT_UNPACK_FTZ_EN
    vecs[12] = '{32'h0000_0001, 2'd1, 32'h0, 25'h0, 8'h0, 2};
    vecs[13] = '{32'h0040_0000, 2'd1, 32'h0, 25'h0, 8'h0, 2};
    vecs[14] = '{32'h8000_0001, 2'd1, 32'h8000_0000, 25'h0, 8'h0, 2};
`else
    vecs[12] = '{32'h0000_0001, 2'd0, 32'h0, 25'h100_0000, 8'h34, 26};
    vecs[13] = '{32'h0040_0000, 2'd0, 32'h0, 25'h100_0000, 8'h3F, 4};
    vecs[14] = '{32'h8000_0001, 2'd3, 32'h7FC0_0000, 25'h0, 8'h0, 2};
`endif

    reset = 1'b1;
    start = 1'b0;
    a_in  = 32'h0;
    #12;
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset sclass/exp_out", {22'd0, sclass, exp_out}, 32'd0);
    check("reset mant_out", {7'd0, mant_out}, 32'd0);
    check("reset special_result", special_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].cls, vecs[i].res, vecs[i].mant, vecs[i].ex, vecs[i].lat,
             32'h0, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Stray start (with a different operand) while busy, and start held in DONE.
    run_op(vecs[12].a, vecs[12].cls, vecs[12].res, vecs[12].mant, vecs[12].ex, vecs[12].lat,
           32'h3F80_0000, Ftz ? 0 : 5, 1'b1, "start while busy");
    run_op(vecs[1].a, vecs[1].cls, vecs[1].res, vecs[1].mant, vecs[1].ex, vecs[1].lat,
           32'hC080_0000, 2, 1'b1, "start in load");

    // Reset during normalisation aborts with all outputs cleared.
    run_op(vecs[0].a, vecs[0].cls, vecs[0].res, vecs[0].mant, vecs[0].ex, vecs[0].lat,
           32'h0, 0, 1'b0, "pre-reset op");
    @(negedge clk);
    a_in  = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (!Ftz) check("busy mid-norm", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort mant_out/exp_out", {mant_out, exp_out[6:0]}, 32'd0);
    check("abort exp_out msb/sclass", {29'd0, exp_out[7], sclass}, 32'd0);
    check("abort special_result", special_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(vecs[1].a, vecs[1].cls, vecs[1].res, vecs[1].mant, vecs[1].ex, vecs[1].lat,
           32'h0, 0, 1'b0, "post-reset op");

    // Randomized operands against the reference model.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: ra[30:23] = 8'h00;
        1: ra[30:23] = 8'hFF;
        2: ra[22:0]  = 23'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ra[31] = 1'b0;
      model(ra, m_cls, m_res, m_mant, m_ex, m_lat);
      run_op(ra, m_cls, m_res, m_mant, m_ex, m_lat, 32'h0, 0, 1'b0,
             $sformatf("rand %h", ra));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
